load_store_multi: RTL and testbench
===================================

Name: load_store_multi

Overview:
- Parametrised multi-channel successor to the single-channel load/store oscillator benchmark.
- Each channel runs a saturating fill/drain counter between 0 and N. Per channel: programmable step, dwell at the top and enable gating. A global mode selects triangle or sawtooth waveform.
- Sits in the benchmark set as a model-checking target: per-channel liveness (FG en -> GF full) and safety (vol <= N) properties.

Parameters:
- NCH, 4, number of independent channels.
- N, 12500, top value of each channel counter.
- CBITS, 14, counter width. Must satisfy 2^CBITS > N + STEP; elaboration-time error otherwise.
- STEP, 1, increment/decrement per enabled cycle, 1 <= STEP <= N.
- HOLD, 2, extra cycles a channel dwells at N. 0 is legal.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  NCH  per-channel advance enable. When low, that channel freezes completely.
- mode  input  1  0 = triangle (fill, hold, drain), 1 = sawtooth (fill, hold, jump to 0).
- vol  output  NCH*CBITS  channel counters, channel i at bits [i*CBITS +: CBITS], registered.
- full  output  NCH  full[i] = (vol[i] == N), registered alongside vol.
- empty  output  NCH  empty[i] = (vol[i] == 0), registered alongside vol.
- wrap  output  NCH  one-cycle pulse in the cycle vol[i] becomes 0 from a nonzero value.
- all_full  output  1  registered AND of the next-state full bits (asserted in the same cycle all full[i] are 1).

Behaviour:
- Reset (rst=1 at edge): every channel gets vol=0, state FILL, hold_cnt=0, full=0, empty=1, wrap=0; all_full=0.
  - Reset overrides en and mode.
  - Reset mid-operation clears everything on the next edge, independent of state.
- Per-channel FSM, evaluated only when en[i]=1; en[i]=0 holds vol, state and hold_cnt, and forces wrap[i]=0.
- FILL:
  - vol <= min(vol+STEP, N), computed in CBITS+1 bits, so no wrap-around.
  - If the result equals N: go to TOP and load hold_cnt <= HOLD.
- TOP (vol == N):
  - If hold_cnt != 0: hold_cnt decrements, vol unchanged.
  - If hold_cnt == 0, exit. mode is sampled here only:
    - mode=0: go to DRAIN, vol <= max(N-STEP, 0).
    - mode=1: go to FILL, vol <= 0, wrap pulses.
  - Result: vol stays at N for exactly HOLD+1 cycles.
- DRAIN:
  - vol <= max(vol-STEP, 0), with saturation (no underflow).
  - If the result is 0: go to FILL and pulse wrap.
  - vol=0 is visible for one cycle, then FILL resumes.
- Boundary cases:
  - STEP not dividing N: saturate at N or 0.
  - STEP=N, HOLD=0, triangle: 0, N, 0, N, …
- Channels are fully independent; the only coupling is all_full.
- Invariant: vol[i] <= N always. full and empty are never both 1 (N >= 1).
- Latency: en[i] rise takes effect on the same edge (no pipeline).

Test Plan:
- N=4, STEP=1, HOLD=2, mode=0, en=all 1, release reset:
  - vol0 over cycles 0..11 = 0,1,2,3,4,4,4,3,2,1,0,1.
  - full high cycles 4-6, wrap pulse cycle 10.
- Same settings, mode=1:
  - vol0 = 0,1,2,3,4,4,4,0,1.
  - wrap pulse cycle 7, period 7.
- N=4, STEP=3, HOLD=0, mode=0:
  - vol0 = 0,3,4,1,0,3.
  - Saturation at both ends; never exceeds 4.
- en[1]=0 for cycles 2-5 while other channels run:
  - vol1 frozen at 2 during that window, then resumes 3,4.
  - all_full asserts only when all four channels are simultaneously at N.
- Toggle mode while in FILL and during TOP with hold_cnt>0:
  - No effect until TOP exit.
  - Mode value at the exit cycle decides drain vs jump.
- Assert rst in DRAIN at vol=2:
  - Next cycle vol=0, empty=1, full=0, wrap=0, all_full=0.
  - Resumes 1,2,… after release.

Source files
------------

// File: rtl/load_store_multi.sv
// Multi-channel saturating fill/drain oscillator: each channel ramps 0..N, dwells at N,
// then drains (triangle) or jumps back to 0 (sawtooth); all_full flags simultaneous tops.
module load_store_multi #(
    parameter int NCH   = 4,
    parameter int N     = 12500,
    parameter int CBITS = 14,
    parameter int STEP  = 1,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic                   mode,
    output logic [NCH*CBITS-1:0]   vol,
    output logic [NCH-1:0]         full,
    output logic [NCH-1:0]         empty,
    output logic [NCH-1:0]         wrap,
    output logic                   all_full
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TOP   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int HBITS = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [CBITS:0]   N_W       = (CBITS+1)'(N);
    localparam logic [CBITS:0]   STEP_W    = (CBITS+1)'(STEP);
    localparam logic [CBITS-1:0] N_C       = CBITS'(N);
    localparam logic [CBITS-1:0] STEP_C    = CBITS'(STEP);
    localparam logic [HBITS-1:0] HOLD_C    = HBITS'(HOLD);
    localparam bit               STEP_EQ_N = (STEP == N);

    if ((2**CBITS) <= (N + STEP)) begin : g_cbits_check
        $error("load_store_multi: CBITS too small, need 2**CBITS > N + STEP");
    end
    if ((STEP < 1) || (STEP > N)) begin : g_step_check
        $error("load_store_multi: STEP must lie in 1..N");
    end

    state_t             state_q [NCH];
    state_t             state_d [NCH];
    logic [CBITS-1:0]   vol_q   [NCH];
    logic [CBITS-1:0]   vol_d   [NCH];
    logic [HBITS-1:0]   hold_q  [NCH];
    logic [HBITS-1:0]   hold_d  [NCH];
    logic [CBITS:0]     fill_sum[NCH];
    logic [NCH-1:0]     full_q, full_d;
    logic [NCH-1:0]     empty_q, empty_d;
    logic [NCH-1:0]     wrap_q, wrap_d;
    logic               all_full_q, all_full_d;

    // Per-channel next state: frozen when disabled, otherwise fill / dwell / drain.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            vol_d[i]    = vol_q[i];
            hold_d[i]   = hold_q[i];
            wrap_d[i]   = 1'b0;
            fill_sum[i] = {1'b0, vol_q[i]} + STEP_W;
            if (en[i]) begin
                case (state_q[i])
                    ST_FILL: begin
                        if (fill_sum[i] >= N_W) begin
                            vol_d[i]   = N_C;
                            state_d[i] = ST_TOP;
                            hold_d[i]  = HOLD_C;
                        end else begin
                            vol_d[i]   = fill_sum[i][CBITS-1:0];
                        end
                    end
                    ST_TOP: begin
                        if (hold_q[i] != {HBITS{1'b0}}) begin
                            hold_d[i] = hold_q[i] - HBITS'(1);
                        end else if (!mode && !STEP_EQ_N) begin
                            vol_d[i]   = N_C - STEP_C;
                            state_d[i] = ST_DRAIN;
                        end else begin
                            // Sawtooth, or a triangle whose single drain step already lands on 0.
                            vol_d[i]   = {CBITS{1'b0}};
                            state_d[i] = ST_FILL;
                            wrap_d[i]  = 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (vol_q[i] > STEP_C) begin
                            vol_d[i]   = vol_q[i] - STEP_C;
                        end else begin
                            vol_d[i]   = {CBITS{1'b0}};
                            state_d[i] = ST_FILL;
                            wrap_d[i]  = (vol_q[i] != {CBITS{1'b0}});
                        end
                    end
                    default: begin
                        vol_d[i]   = {CBITS{1'b0}};
                        state_d[i] = ST_FILL;
                        hold_d[i]  = {HBITS{1'b0}};
                    end
                endcase
            end else begin
                wrap_d[i] = 1'b0;
            end
            full_d[i]  = (vol_d[i] == N_C);
            empty_d[i] = (vol_d[i] == {CBITS{1'b0}});
        end
        all_full_d = &full_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_FILL;
                vol_q[i]   <= {CBITS{1'b0}};
                hold_q[i]  <= {HBITS{1'b0}};
            end
            full_q     <= {NCH{1'b0}};
            empty_q    <= {NCH{1'b1}};
            wrap_q     <= {NCH{1'b0}};
            all_full_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                vol_q[i]   <= vol_d[i];
                hold_q[i]  <= hold_d[i];
            end
            full_q     <= full_d;
            empty_q    <= empty_d;
            wrap_q     <= wrap_d;
            all_full_q <= all_full_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_vol_out
        assign vol[g*CBITS +: CBITS] = vol_q[g];
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign wrap     = wrap_q;
    assign all_full = all_full_q;

endmodule

// File: tb/tb_load_store_multi.sv
// Bench for load_store_multi: two instances (STEP=1/HOLD=2 and STEP=3/HOLD=0, N=4) checked each
// cycle against a waveform-table model, plus hand-computed literal sequences.
module tb_load_store_multi;

    localparam int NCH = 4;
    localparam int N   = 4;
    localparam int CB  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                mode;
    logic [NCH-1:0]      en;
    logic [NCH*CB-1:0]   vol_a, vol_b;
    logic [NCH-1:0]      full_a, empty_a, wrap_a;
    logic [NCH-1:0]      full_b, empty_b, wrap_b;
    logic                af_a, af_b;

    always #5 clk = ~clk;

    load_store_multi #(.NCH(NCH), .N(N), .CBITS(CB), .STEP(1), .HOLD(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .vol(vol_a),
        .full(full_a), .empty(empty_a), .wrap(wrap_a), .all_full(af_a)
    );

    load_store_multi #(.NCH(NCH), .N(N), .CBITS(CB), .STEP(3), .HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .vol(vol_b),
        .full(full_b), .empty(empty_b), .wrap(wrap_b), .all_full(af_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: one period of the triangle waveform per instance; the sawtooth is its rising prefix.
    int seq [2][32];
    int rise_len [2];
    int tri_len  [2];
    int idx  [2][NCH];
    bit mwrap[2][NCH];
    bit maf  [2];

    int ha [0:31];
    int hb [0:31];
    int h1 [0:31];
    bit fa [0:31];
    bit wa [0:31];
    bit afa[0:31];

    int exp_tri [12] = '{0, 1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 1};
    int exp_saw [9]  = '{0, 1, 2, 3, 4, 4, 4, 0, 1};
    int exp_b   [6]  = '{0, 3, 4, 1, 0, 3};
    int exp_frz [8]  = '{0, 1, 2, 2, 2, 2, 3, 4};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_seq(input int d, input int step, input int hold);
        int len;
        int v;
        len = 0;
        v = 0;
        seq[d][len] = 0; len++;
        while (v < N) begin
            v = (v + step > N) ? N : v + step;
            seq[d][len] = v; len++;
        end
        for (int k = 0; k < hold; k++) begin
            seq[d][len] = N; len++;
        end
        rise_len[d] = len;
        v = N;
        while (1) begin
            v = (v - step < 0) ? 0 : v - step;
            if (v == 0) break;
            seq[d][len] = v; len++;
        end
        tri_len[d] = len;
    endtask

    task automatic model_update();
        int nidx;
        int old;
        bit allf;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int c = 0; c < NCH; c++) begin
                    idx[d][c]   = 0;
                    mwrap[d][c] = 1'b0;
                end
                maf[d] = 1'b0;
            end else begin
                allf = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    if (en[c]) begin
                        old = seq[d][idx[d][c]];
                        if (idx[d][c] == rise_len[d] - 1 && mode)
                            nidx = 0;
                        else
                            nidx = (idx[d][c] + 1) % tri_len[d];
                        mwrap[d][c] = (seq[d][nidx] == 0) && (old != 0);
                        idx[d][c]   = nidx;
                    end else begin
                        mwrap[d][c] = 1'b0;
                    end
                    allf = allf && (seq[d][idx[d][c]] == N);
                end
                maf[d] = allf;
            end
        end
    endtask

    task automatic compare();
        logic [NCH*CB-1:0] v;
        logic [NCH-1:0]    f, e, w;
        logic              af;
        int                ev;
        for (int d = 0; d < 2; d++) begin
            v  = (d == 0) ? vol_a   : vol_b;
            f  = (d == 0) ? full_a  : full_b;
            e  = (d == 0) ? empty_a : empty_b;
            w  = (d == 0) ? wrap_a  : wrap_b;
            af = (d == 0) ? af_a    : af_b;
            for (int c = 0; c < NCH; c++) begin
                ev = seq[d][idx[d][c]];
                chk($sformatf("d%0d ch%0d vol @%0t", d, c, $time), int'(v[c*CB +: CB]), ev);
                chk($sformatf("d%0d ch%0d full @%0t", d, c, $time), int'(f[c]), int'(ev == N));
                chk($sformatf("d%0d ch%0d empty @%0t", d, c, $time), int'(e[c]), int'(ev == 0));
                chk($sformatf("d%0d ch%0d wrap @%0t", d, c, $time), int'(w[c]), int'(mwrap[d][c]));
            end
            chk($sformatf("d%0d all_full @%0t", d, $time), int'(af), int'(maf[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic record(input int k);
        ha[k]  = int'(vol_a[CB-1:0]);
        h1[k]  = int'(vol_a[2*CB-1:CB]);
        hb[k]  = int'(vol_b[CB-1:0]);
        fa[k]  = full_a[0];
        wa[k]  = wrap_a[0];
        afa[k] = af_a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        en   = 4'b1111;
        build_seq(0, 1, 2);
        build_seq(1, 3, 0);

        // Triangle, all channels in lockstep.
        do_reset();
        chk("reset vol_a", int'(vol_a), 0);
        chk("reset empty_a", int'(empty_a), 15);
        chk("reset full_a", int'(full_a), 0);
        chk("reset wrap_a", int'(wrap_a), 0);
        chk("reset all_full_a", int'(af_a), 0);
        record(0);
        for (int k = 1; k < 12; k++) begin
            tick();
            record(k);
        end
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("tri vol0 c%0d", k), ha[k], exp_tri[k]);
            chk($sformatf("tri full0 c%0d", k), int'(fa[k]), int'(k >= 4 && k <= 6));
            chk($sformatf("tri wrap0 c%0d", k), int'(wa[k]), int'(k == 10));
            chk($sformatf("tri all_full c%0d", k), int'(afa[k]), int'(k >= 4 && k <= 6));
        end
        for (int k = 0; k < 6; k++)
            chk($sformatf("step3 vol0 c%0d", k), hb[k], exp_b[k]);

        // Sawtooth.
        mode = 1'b1;
        do_reset();
        record(0);
        for (int k = 1; k < 16; k++) begin
            tick();
            record(k);
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("saw vol0 c%0d", k), ha[k], exp_saw[k]);
        for (int k = 0; k < 16; k++)
            chk($sformatf("saw wrap0 c%0d", k), int'(wa[k]), int'(k == 7 || k == 14));
        chk("saw vol0 c14", ha[14], 0);

        // Channel 1 frozen for three edges.
        mode = 1'b0;
        do_reset();
        record(0);
        for (int k = 1; k < 10; k++) begin
            en = (k >= 3 && k <= 5) ? 4'b1101 : 4'b1111;
            tick();
            record(k);
        end
        en = 4'b1111;
        for (int k = 0; k < 8; k++)
            chk($sformatf("freeze vol1 c%0d", k), h1[k], exp_frz[k]);
        for (int k = 0; k < 10; k++)
            chk($sformatf("freeze all_full c%0d", k), int'(afa[k]), 0);
        chk("freeze vol0 c6", ha[6], 4);

        // Mode toggles only matter at the TOP exit edge.
        do_reset();
        record(0);
        for (int k = 1; k < 19; k++) begin
            mode = (k inside {1, 2, 3, 5, 6, 8, 9, 11, 13, 17});
            tick();
            record(k);
        end
        chk("modetog vol0 c6", ha[6], 4);
        chk("modetog vol0 c7", ha[7], 3);
        chk("modetog vol0 c10", ha[10], 0);
        chk("modetog vol0 c16", ha[16], 4);
        chk("modetog vol0 c17", ha[17], 0);
        chk("modetog wrap0 c17", int'(wa[17]), 1);
        chk("modetog vol0 c18", ha[18], 1);

        // Reset in the middle of a drain.
        mode = 1'b0;
        do_reset();
        for (int k = 1; k < 9; k++) begin
            tick();
            record(k);
        end
        chk("drain vol0 c8", ha[8], 2);
        rst = 1'b1;
        tick();
        chk("midrst vol_a", int'(vol_a), 0);
        chk("midrst empty_a", int'(empty_a), 15);
        chk("midrst full_a", int'(full_a), 0);
        chk("midrst wrap_a", int'(wrap_a), 0);
        chk("midrst all_full_a", int'(af_a), 0);
        rst = 1'b0;
        tick();
        chk("postrst vol0 1", int'(vol_a[CB-1:0]), 1);
        tick();
        chk("postrst vol0 2", int'(vol_a[CB-1:0]), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
